dec_4to16: RTL and testbench

//   Registered 4-to-16 one-hot decoder with enable. Converts a 4-bit binary

---
 rtl/dec_4to16.sv | 110 +++++++++++
 tb/tb_dec_4to16.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dec_4to16.sv
// -----------------------------------------------------------------------------
// dec_4to16 -- registered 4-to-16 one-hot decoder with enable
//
// Purpose
//   Turns a 4-bit binary select into a 16-bit one-hot word for chip-select or
//   row-select logic downstream. The decoded word is registered, so y follows
//   en/w with exactly one cycle of latency. A new code is taken every cycle.
//
// Parameters
//   ACTIVE_LOW  0: the selected line is 1 and all other lines are 0
//               1: the selected line is 0 and all other lines are 1
//
// Ports
//   clk  in   1       system clock, all state updates on the rising edge
//   rst  in   1       synchronous, active-high reset (priority over en and w)
//   en   in   1       decode enable; 0 drives every line inactive
//   w    in   4       binary select code, 0..15
//   y    out  [0:15]  registered decoded lines; y[0] is the leftmost (MSB)
//   err  out  1       sticky one-hot check error; present only in the
//                     DEC_4TO16_ONEHOT_CHK_EN build
//
// Interface timing
//   No handshake. The decoder is always ready: each rising edge with rst=0
//   captures en/w, and the result appears on y after that edge.
//
// Build option
//   DEC_4TO16_ONEHOT_CHK_EN defined : adds err and a registered checker that
//                                     watches y against the en that made it.
//   DEC_4TO16_ONEHOT_CHK_EN undefined: no err port and no checker logic.
//   The decode path is the same in both builds.
// -----------------------------------------------------------------------------
module dec_4to16 #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  w,
    output logic [0:15] y
`ifdef DEC_4TO16_ONEHOT_CHK_EN
    ,
    output logic        err
`endif
);

    // Pattern with no line selected, in the configured polarity.
    localparam logic [0:15] INACTIVE = ACTIVE_LOW ? 16'hFFFF : 16'h0000;

    // Active-high one-hot word. Because the vector is declared [0:15],
    // code 0 lands on the leftmost bit and code 15 on the rightmost.
    logic [0:15] onehot;
    logic [0:15] y_next;

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[w] = 1'b1;
        end
    end

    // Fold in the output polarity before the register, so y comes straight
    // off a flop with no logic after it.
    always_comb begin
        y_next = ACTIVE_LOW ? ~onehot : onehot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y <= INACTIVE;
        end else begin
            y <= y_next;
        end
    end

`ifdef DEC_4TO16_ONEHOT_CHK_EN
    // The checker looks at the y now on the register. That y was produced by
    // the en captured at the same edge, so en is delayed by one cycle to line
    // up with it. After reset, y is inactive, which matches en_q = 0.
    logic        en_q;
    logic [15:0] act_bits;
    logic        is_onehot;
    logic        is_inactive;
    logic        bad;

    always_comb begin
        // Bring y to active-high form so one test covers both polarities.
        act_bits    = ACTIVE_LOW ? ~y : y;
        // Exactly one bit set: nonzero, and clearing the lowest set bit
        // leaves nothing.
        is_onehot   = (act_bits != 16'h0000) &&
                      ((act_bits & (act_bits - 16'd1)) == 16'h0000);
        is_inactive = (y == INACTIVE);
        bad         = en_q ? !is_onehot : !is_inactive;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q <= 1'b0;
            err  <= 1'b0;
        end else begin
            en_q <= en;
            // Sticky: once set, err holds until the next reset.
            if (bad) begin
                err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dec_4to16.sv
// -----------------------------------------------------------------------------
// tb_dec_4to16 -- bench for dec_4to16
//
// Two instances share the same inputs: u_hi (ACTIVE_LOW=0) and u_lo
// (ACTIVE_LOW=1). The bench drives inputs on the falling edge and samples
// 1 time unit after the rising edge.
//
// Phase 1 applies a table of directed vectors. Each entry holds hand-written
// expected values for ACTIVE_LOW=0, and u_lo is checked against the bitwise
// inverse of that value.
// Phase 2 applies random stimulus. Each expected value comes from a reference
// model that computes the result with a plain shift and is pushed onto a
// queue for the scoreboard.
// -----------------------------------------------------------------------------
module tb_dec_4to16;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [3:0]  w   = 4'd0;
    logic [0:15] y_hi;
    logic [0:15] y_lo;
`ifdef DEC_4TO16_ONEHOT_CHK_EN
    logic        err_hi;
    logic        err_lo;
`endif

    always #5 clk = ~clk;

    dec_4to16 #(.ACTIVE_LOW(1'b0)) u_hi (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .w   (w),
        .y   (y_hi)
`ifdef DEC_4TO16_ONEHOT_CHK_EN
        ,
        .err (err_hi)
`endif
    );

    dec_4to16 #(.ACTIVE_LOW(1'b1)) u_lo (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .w   (w),
        .y   (y_lo)
`ifdef DEC_4TO16_ONEHOT_CHK_EN
        ,
        .err (err_lo)
`endif
    );

    // ---------------- counters / scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model. Code w selects bit position w counted from the left,
    // which in a 16-bit word is 2**(15-w). Reset and en=0 give no line.
    function automatic logic [15:0] model(input logic r, input logic e,
                                          input logic [3:0] sel);
        if (r || !e) return 16'h0000;
        return 16'h8000 >> sel;
    endfunction

    // ---------------- driver ----------------
    // Drive one cycle's inputs, clock them in, and sample just after the edge.
    task automatic drive(input logic r, input logic e, input logic [3:0] sel);
        @(negedge clk);
        rst = r;
        en  = e;
        w   = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic check_err(input string name);
`ifdef DEC_4TO16_ONEHOT_CHK_EN
        check({name, "_err_hi"}, {15'd0, err_hi}, 16'h0000);
        check({name, "_err_lo"}, {15'd0, err_lo}, 16'h0000);
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  w;
        logic [15:0] y_exp;   // expected value for ACTIVE_LOW=0
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic e, input logic [3:0] sel,
                                input logic [15:0] ye, input string nm);
        vec_t v;
        v.rst = r; v.en = e; v.w = sel; v.y_exp = ye; v.name = nm;
        return v;
    endfunction

    initial begin
        // Reset held for two cycles, with decode requested underneath it.
        vecs.push_back(mk(1, 1, 5,  16'h0000, "rst_hold0"));
        vecs.push_back(mk(1, 1, 5,  16'h0000, "rst_hold1"));
        vecs.push_back(mk(0, 1, 5,  16'h0400, "rst_release_w5"));
        // Enable off, then on.
        vecs.push_back(mk(0, 0, 0,  16'h0000, "en0_w0"));
        vecs.push_back(mk(0, 1, 0,  16'h8000, "en1_w0"));
        // Walk all sixteen codes, then wrap back to 0.
        vecs.push_back(mk(0, 1, 0,  16'h8000, "walk0"));
        vecs.push_back(mk(0, 1, 1,  16'h4000, "walk1"));
        vecs.push_back(mk(0, 1, 2,  16'h2000, "walk2"));
        vecs.push_back(mk(0, 1, 3,  16'h1000, "walk3"));
        vecs.push_back(mk(0, 1, 4,  16'h0800, "walk4"));
        vecs.push_back(mk(0, 1, 5,  16'h0400, "walk5"));
        vecs.push_back(mk(0, 1, 6,  16'h0200, "walk6"));
        vecs.push_back(mk(0, 1, 7,  16'h0100, "walk7"));
        vecs.push_back(mk(0, 1, 8,  16'h0080, "walk8"));
        vecs.push_back(mk(0, 1, 9,  16'h0040, "walk9"));
        vecs.push_back(mk(0, 1, 10, 16'h0020, "walk10"));
        vecs.push_back(mk(0, 1, 11, 16'h0010, "walk11"));
        vecs.push_back(mk(0, 1, 12, 16'h0008, "walk12"));
        vecs.push_back(mk(0, 1, 13, 16'h0004, "walk13"));
        vecs.push_back(mk(0, 1, 14, 16'h0002, "walk14"));
        vecs.push_back(mk(0, 1, 15, 16'h0001, "walk15"));
        vecs.push_back(mk(0, 1, 0,  16'h8000, "wrap0"));
        // One-cycle reset in the middle of a sequence.
        vecs.push_back(mk(0, 1, 9,  16'h0040, "pre_rst_w9"));
        vecs.push_back(mk(1, 1, 9,  16'h0000, "mid_rst"));
        vecs.push_back(mk(0, 1, 9,  16'h0040, "post_rst_w9"));
        // Enable toggling.
        vecs.push_back(mk(0, 0, 7,  16'h0000, "tog_en0"));
        vecs.push_back(mk(0, 1, 7,  16'h0100, "tog_en1"));
        vecs.push_back(mk(0, 0, 7,  16'h0000, "tog_en0b"));
        vecs.push_back(mk(0, 1, 3,  16'h1000, "tog_en1_w3"));
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] exp;
        logic        r;
        logic        e;
        logic [3:0]  sel;

        #0;
        // Phase 1: the directed table.
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].w);
            check({vecs[i].name, "_hi"}, y_hi,  vecs[i].y_exp);
            check({vecs[i].name, "_lo"}, y_lo, ~vecs[i].y_exp);
            check_err(vecs[i].name);
        end

        // Hand-written check of the active-low values for w=3 and en=0.
        drive(0, 1, 3);
        check("al_w3", y_lo, 16'hEFFF);
        drive(0, 0, 3);
        check("al_en0", y_lo, 16'hFFFF);

        // Phase 2: random stimulus scored against the model.
        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 19) == 0);
            e   = ($urandom_range(0, 3) != 0);
            sel = 4'($urandom_range(0, 15));
            exp_q.push_back(model(r, e, sel));
            drive(r, e, sel);
            exp = exp_q.pop_front();
            check("rand_hi", y_hi,  exp);
            check("rand_lo", y_lo, ~exp);
            if (!r) check_err("rand");
        end

        // Final reset: everything returns to idle.
        drive(1, 1, 12);
        check("final_rst_hi", y_hi, 16'h0000);
        check("final_rst_lo", y_lo, 16'hFFFF);
        check_err("final_rst");

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog, so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $finish;
    end

endmodule
